// File: rtl/alu8_operand_sequencer.sv
// Operand sequencer around the 8-bit add/mul/compare/subtract datapath: byte stream in, A/B held, result captured.
// Optional SEQ_TXN_COUNT_EN adds an 8-bit count of completed output handshakes on port txn_count.
module alu8_operand_sequencer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [7:0]  a_o,
  output logic [7:0]  b_o,
  input  logic [15:0] result_i,
  output logic        out_valid,
  output logic [15:0] out_data,
  input  logic        out_ready
`ifdef SEQ_TXN_COUNT_EN
  ,
  output logic [7:0]  txn_count
`endif
);

  typedef enum logic [1:0] {LOAD_A, LOAD_B, SETTLE, HOLD} state_t;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [3:0] count;

  // Upstream may only present bytes while an operand slot is open.
  assign in_ready = (state == LOAD_A) || (state == LOAD_B);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD_A;
      a_o       <= 8'h00;
      b_o       <= 8'h00;
      out_data  <= 16'h0000;
      out_valid <= 1'b0;
      count     <= 4'd0;
    end else begin
      case (state)
        LOAD_A: begin
          if (in_valid) begin
            a_o   <= in_data;
            state <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (in_valid) begin
            b_o   <= in_data;
            count <= SETTLE_INIT;
            state <= SETTLE;
          end
        end
        SETTLE: begin
          // Result is taken exactly SETTLE_CYCLES edges after the B handshake.
          if (count == 4'd0) begin
            out_data  <= result_i;
            out_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            count <= count - 4'd1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= LOAD_A;
          end
        end
        default: state <= LOAD_A;
      endcase
    end
  end

`ifdef SEQ_TXN_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      txn_count <= 8'd0;
    end else if ((state == HOLD) && out_ready) begin
      txn_count <= txn_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu8_operand_sequencer.sv
// Directed bench for alu8_operand_sequencer: transaction-level model checked every cycle plus literal expectations.
module tb_alu8_operand_sequencer;
  localparam int SC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic [7:0]  a_o, b_o;
  logic [15:0] result_i;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready = 1'b1;
  logic        ovr_en = 1'b0;
  logic [15:0] ovr_val = 16'h0000;
`ifdef SEQ_TXN_COUNT_EN
  logic [7:0]  txn_count;
`endif

  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Stand-in for the combinational datapath: product of the held operands.
  assign result_i = ovr_en ? ovr_val : 16'(a_o * b_o);

  alu8_operand_sequencer #(.SETTLE_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .a_o(a_o), .b_o(b_o), .result_i(result_i), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready)
`ifdef SEQ_TXN_COUNT_EN
    , .txn_count(txn_count)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: operands collected in order, result taken SC edges after B, held until accepted.
  bit        m_have_a = 0, m_have_b = 0, m_holding = 0;
  int        m_since_b = 0;
  logic [7:0]  m_a = 0, m_b = 0;
  logic [15:0] m_out = 0;
  int        m_txns = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_have_a = 0; m_have_b = 0; m_holding = 0; m_since_b = 0;
      m_a = 0; m_b = 0; m_out = 0; m_txns = 0;
    end else if (m_holding) begin
      if (out_ready) begin
        m_holding = 0; m_have_a = 0; m_have_b = 0;
        m_txns = m_txns + 1;
      end
    end else if (m_have_b) begin
      m_since_b = m_since_b + 1;
      if (m_since_b == SC) begin
        m_out = ovr_en ? ovr_val : 16'(int'(m_a) * int'(m_b));
        m_holding = 1;
      end
    end else if (in_valid) begin
      if (!m_have_a) begin
        m_a = in_data; m_have_a = 1;
      end else begin
        m_b = in_data; m_have_b = 1; m_since_b = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready", 32'(in_ready), 32'(!m_have_b));
    chk("a_o", 32'(a_o), 32'(m_a));
    chk("b_o", 32'(b_o), 32'(m_b));
    chk("out_valid", 32'(out_valid), 32'(m_holding));
    chk("out_data", 32'(out_data), 32'(m_out));
`ifdef SEQ_TXN_COUNT_EN
    chk("txn_count", 32'(txn_count), 32'(m_txns % 256));
`endif
  end

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input logic [7:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) chk("valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic txn(input logic [7:0] a, input logic [7:0] b);
    send(a);
    send(b);
    wait_valid();
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_a", 32'(a_o), 32'd0);
    rst = 1'b0;

    // 0x12 * 0x34, with exact capture latency
    send(8'h12);
    send(8'h34);
    $display("txn: A=0x12 B=0x34 accepted");
    chk("t1_a", 32'(a_o), 32'h12);
    chk("t1_b", 32'(b_o), 32'h34);
    chk("t1_valid_e0", 32'(out_valid), 32'd0);
    for (int j = 1; j < SC; j++) begin
      @(negedge clk);
      chk("t1_valid_early", 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    chk("t1_valid_at_sc", 32'(out_valid), 32'd1);
    chk("t1_data", 32'(out_data), 32'h03A8);
    @(negedge clk);
    chk("t1_done", 32'(out_valid), 32'd0);
    $display("txn: out_data=0x%0h", 16'h03A8);

    // 0xFF * 0xFF with back-pressure, and ignored bytes during SETTLE/HOLD
    out_ready = 1'b0;
    send(8'hFF);
    send(8'hFF);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    wait_valid();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data", 32'(out_data), 32'hFE01);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_a", 32'(a_o), 32'hFF);
      chk("bp_b", 32'(b_o), 32'hFF);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", 32'(out_valid), 32'd0);
    chk("bp_load_a", 32'(in_ready), 32'd1);
    $display("txn: A=0xFF B=0xFF out_data=0xFE01 after back-pressure");

    // Result sampled at exactly one edge
    send(8'h05);
    send(8'h06);
    ovr_en  = 1'b1;
    ovr_val = 16'h1111;
    for (int j = 1; j < SC; j++) @(negedge clk);
    ovr_val = 16'h2222;
    @(negedge clk);
    ovr_val = 16'h3333;
    chk("sample_data", 32'(out_data), 32'h2222);
    @(negedge clk);
    ovr_en = 1'b0;
    $display("txn: sampled result 0x2222");

    // Abort in LOAD_B
    send(8'h77);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_b_a", 32'(a_o), 32'd0);
    chk("abort_b_b", 32'(b_o), 32'd0);
    chk("abort_b_ready", 32'(in_ready), 32'd1);
    chk("abort_b_data", 32'(out_data), 32'd0);
    $display("txn: abort in LOAD_B");

    // Abort in SETTLE
    send(8'h09);
    send(8'h0A);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_s_valid", 32'(out_valid), 32'd0);
    chk("abort_s_a", 32'(a_o), 32'd0);
    chk("abort_s_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < SC + 2; k++) begin
      @(negedge clk);
      chk("abort_s_quiet", 32'(out_valid), 32'd0);
    end
    $display("txn: abort in SETTLE");

`ifdef SEQ_TXN_COUNT_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int t = 1; t <= 257; t++) begin
      txn(8'(t), 8'(t + 3));
      if (t == 1)   chk("cnt_1", 32'(txn_count), 32'd1);
      if (t == 256) chk("cnt_256", 32'(txn_count), 32'd0);
      if (t == 257) chk("cnt_257", 32'(txn_count), 32'd1);
      $display("txn %0d: count=%0d", t, txn_count);
    end
`else
    txn(8'h03, 8'h07);
    chk("final_data", 32'(out_data), 32'd21);
    $display("txn: A=0x03 B=0x07 out_data=21");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
